// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: hazard detection and forwarding control for a 5-stage MIPS
// pipeline (F/D/E/M/W). The block keeps shadow copies of the E/M/W destination
// registers and their Tnew values. It compares them with the Tuse of the
// instruction in D to decide stalls and forwarding-mux selects. It also tracks
// whether the multiply/divide unit is still busy.
//
// Ports:
//   clk, reset        rising-edge clock; asynchronous active-low reset
//   D_rs/D_rt         source register fields of the instruction in D
//   D_tuse_rs/_rt     cycles until the source is needed (3 = not used)
//   D_wa/D_tnew       destination register and its Tnew on entering E
//   D_md/_start/_div  HI/LO access, MDU start, divide qualifier
//   stall             freeze PC and F/D, insert a bubble into E
//   fwd_d_rs/rt_sel   D mux: 0 RF, 1 E, 2 M, 3 W
//   fwd_e_rs/rt_sel   E mux: 0 pipeline reg, 1 M, 2 W
//   fwd_m_rt_sel      M store-data mux: 0 pipeline reg, 1 W
//   md_busy           MDU busy
module hazard_fwd_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_tuse_rs,
  input  logic [1:0] D_tuse_rt,
  input  logic [4:0] D_wa,
  input  logic [1:0] D_tnew,
  input  logic       D_md,
  input  logic       D_md_start,
  input  logic       D_md_div,
  output logic       stall,
  output logic [1:0] fwd_d_rs_sel,
  output logic [1:0] fwd_d_rt_sel,
  output logic [1:0] fwd_e_rs_sel,
  output logic [1:0] fwd_e_rt_sel,
  output logic       fwd_m_rt_sel,
  output logic       md_busy
);

  localparam int unsigned RW = 5;  // register index width
  localparam int unsigned TW = 2;  // Tuse/Tnew width
  localparam int unsigned CW = 4;  // MDU counter width

  // Shadow pipeline state
  logic [RW-1:0] e_rs, e_rt, e_wa;
  logic [TW-1:0] e_tnew;
  logic          e_md_start, e_md_div;
  logic [RW-1:0] m_rt, m_wa;
  logic [TW-1:0] m_tnew;
  logic [RW-1:0] w_wa;
  logic [TW-1:0] w_tnew;
  logic [CW-1:0] mdu_cnt;

  // Tnew one stage later, saturating at zero
  function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // Register hazard for one source: the nearest E/M producer is not ready in time
  function automatic logic src_stall(
    input logic [RW-1:0] r,    input logic [TW-1:0] tuse,
    input logic [RW-1:0] ewa,  input logic [TW-1:0] etn,
    input logic [RW-1:0] mwa,  input logic [TW-1:0] mtn
  );
    if (r == '0 || tuse == 2'd3) return 1'b0;
    if (ewa == r) return etn > tuse;
    if (mwa == r) return mtn > tuse;
    return 1'b0;
  endfunction

  // D forward select: the nearest producer wins; a producer that is not ready yields 0
  function automatic logic [1:0] d_sel(
    input logic [RW-1:0] r,
    input logic [RW-1:0] ewa, input logic [TW-1:0] etn,
    input logic [RW-1:0] mwa, input logic [TW-1:0] mtn,
    input logic [RW-1:0] wwa, input logic [TW-1:0] wtn
  );
    if (r == '0) return 2'd0;
    if (ewa == r) return (etn == '0) ? 2'd1 : 2'd0;
    if (mwa == r) return (mtn == '0) ? 2'd2 : 2'd0;
    if (wwa == r) return (wtn == '0) ? 2'd3 : 2'd0;
    return 2'd0;
  endfunction

  // E forward select: search M, then W
  function automatic logic [1:0] e_sel(
    input logic [RW-1:0] r,
    input logic [RW-1:0] mwa, input logic [TW-1:0] mtn,
    input logic [RW-1:0] wwa, input logic [TW-1:0] wtn
  );
    if (r == '0) return 2'd0;
    if (mwa == r) return (mtn == '0) ? 2'd1 : 2'd0;
    if (wwa == r) return (wtn == '0) ? 2'd2 : 2'd0;
    return 2'd0;
  endfunction

  // Combinational hazard and forwarding decisions
  always_comb begin
    md_busy      = e_md_start | (mdu_cnt != '0);
    stall        = src_stall(D_rs, D_tuse_rs, e_wa, e_tnew, m_wa, m_tnew)
                 | src_stall(D_rt, D_tuse_rt, e_wa, e_tnew, m_wa, m_tnew)
                 | (D_md & md_busy);
    fwd_d_rs_sel = d_sel(D_rs, e_wa, e_tnew, m_wa, m_tnew, w_wa, w_tnew);
    fwd_d_rt_sel = d_sel(D_rt, e_wa, e_tnew, m_wa, m_tnew, w_wa, w_tnew);
    fwd_e_rs_sel = e_sel(e_rs, m_wa, m_tnew, w_wa, w_tnew);
    fwd_e_rt_sel = e_sel(e_rt, m_wa, m_tnew, w_wa, w_tnew);
    fwd_m_rt_sel = (m_rt != '0) && (w_wa == m_rt) && (w_tnew == '0);
  end

  // Shadow pipeline advance and MDU busy counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_rs       <= '0;
      e_rt       <= '0;
      e_wa       <= '0;
      e_tnew     <= '0;
      e_md_start <= 1'b0;
      e_md_div   <= 1'b0;
      m_rt       <= '0;
      m_wa       <= '0;
      m_tnew     <= '0;
      w_wa       <= '0;
      w_tnew     <= '0;
      mdu_cnt    <= '0;
    end else begin
      m_rt   <= e_rt;
      m_wa   <= e_wa;
      m_tnew <= tnew_dec(e_tnew);
      w_wa   <= m_wa;
      w_tnew <= tnew_dec(m_tnew);
      if (stall) begin
        // Bubble; the stalled D instruction is re-presented next cycle
        e_rs       <= '0;
        e_rt       <= '0;
        e_wa       <= '0;
        e_tnew     <= '0;
        e_md_start <= 1'b0;
        e_md_div   <= 1'b0;
      end else begin
        e_rs       <= D_rs;
        e_rt       <= D_rt;
        e_wa       <= D_wa;
        e_tnew     <= D_tnew;
        e_md_start <= D_md_start;
        e_md_div   <= D_md_div;
      end
      if (e_md_start)
        mdu_cnt <= e_md_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      else if (mdu_cnt != '0)
        mdu_cnt <= mdu_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl. The stimulus process drives one D
// instruction per cycle and queues the expected outputs for that cycle. The
// monitor pops one entry from the queue and compares it on each falling edge.
module tb_hazard_fwd_ctrl;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] trs;
    logic [1:0] trt;
    logic [4:0] wa;
    logic [1:0] tnew;
    logic       md;
    logic       st;
    logic       dv;
  } d_t;

  typedef struct packed {
    logic       stall;
    logic [1:0] drs;
    logic [1:0] drt;
    logic [1:0] ers;
    logic [1:0] ert;
    logic       mrt;
    logic       busy;
  } exp_t;

  typedef struct {
    exp_t  e;
    string nm;
  } sb_t;

  logic       clk;
  logic       reset;
  logic [4:0] D_rs, D_rt, D_wa;
  logic [1:0] D_tuse_rs, D_tuse_rt, D_tnew;
  logic       D_md, D_md_start, D_md_div;
  logic       stall, fwd_m_rt_sel, md_busy;
  logic [1:0] fwd_d_rs_sel, fwd_d_rt_sel, fwd_e_rs_sel, fwd_e_rt_sel;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  hazard_fwd_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
    .D_wa(D_wa), .D_tnew(D_tnew), .D_md(D_md), .D_md_start(D_md_start),
    .D_md_div(D_md_div), .stall(stall),
    .fwd_d_rs_sel(fwd_d_rs_sel), .fwd_d_rt_sel(fwd_d_rt_sel),
    .fwd_e_rs_sel(fwd_e_rs_sel), .fwd_e_rt_sel(fwd_e_rt_sel),
    .fwd_m_rt_sel(fwd_m_rt_sel), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic d_t mk_d(int rs, int rt, int trs, int trt, int wa, int tnew,
                              int md, int st, int dv);
    d_t d;
    d.rs = 5'(rs); d.rt = 5'(rt); d.trs = 2'(trs); d.trt = 2'(trt);
    d.wa = 5'(wa); d.tnew = 2'(tnew); d.md = 1'(md); d.st = 1'(st); d.dv = 1'(dv);
    return d;
  endfunction

  function automatic exp_t mk_e(int s, int drs, int drt, int ers, int ert, int mrt, int busy);
    exp_t e;
    e.stall = 1'(s); e.drs = 2'(drs); e.drt = 2'(drt); e.ers = 2'(ers);
    e.ert = 2'(ert); e.mrt = 1'(mrt); e.busy = 1'(busy);
    return e;
  endfunction

  task automatic apply(input d_t d);
    D_rs = d.rs; D_rt = d.rt; D_tuse_rs = d.trs; D_tuse_rt = d.trt;
    D_wa = d.wa; D_tnew = d.tnew; D_md = d.md; D_md_start = d.st; D_md_div = d.dv;
  endtask

  task automatic expect_now(input exp_t e, input string nm);
    sb_t item;
    item.e  = e;
    item.nm = nm;
    sb.push_back(item);
  endtask

  task automatic drive(input d_t d, input exp_t e, input string nm);
    @(posedge clk);
    #1;
    apply(d);
    expect_now(e, nm);
  endtask

  // Monitor: one comparison per queued expectation, mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        sb_t  item;
        exp_t act;
        item = sb.pop_front();
        act.stall = stall;        act.drs = fwd_d_rs_sel; act.drt = fwd_d_rt_sel;
        act.ers   = fwd_e_rs_sel; act.ert = fwd_e_rt_sel; act.mrt = fwd_m_rt_sel;
        act.busy  = md_busy;
        checks++;
        if (act !== item.e) begin
          errors++;
          $display("FAIL %s: got stall=%0d drs=%0d drt=%0d ers=%0d ert=%0d mrt=%0d busy=%0d, expected stall=%0d drs=%0d drt=%0d ers=%0d ert=%0d mrt=%0d busy=%0d",
                   item.nm, act.stall, act.drs, act.drt, act.ers, act.ert, act.mrt, act.busy,
                   item.e.stall, item.e.drs, item.e.drt, item.e.ers, item.e.ert, item.e.mrt,
                   item.e.busy);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    d_t   nop, lw1, add4, add3, beq3, jal31, jr31, add0, rd0, w1, w2, w3, rd5;
    d_t   mult, divi, mfhi;
    exp_t z, st, busy;

    nop   = mk_d(0, 0, 3, 3, 0, 0, 0, 0, 0);
    lw1   = mk_d(2, 0, 1, 3, 1, 2, 0, 0, 0);
    add4  = mk_d(1, 6, 1, 1, 4, 1, 0, 0, 0);
    add3  = mk_d(7, 8, 1, 1, 3, 1, 0, 0, 0);
    beq3  = mk_d(3, 0, 0, 0, 0, 0, 0, 0, 0);
    jal31 = mk_d(0, 0, 3, 3, 31, 0, 0, 0, 0);
    jr31  = mk_d(31, 0, 0, 3, 0, 0, 0, 0, 0);
    add0  = mk_d(9, 10, 1, 1, 0, 1, 0, 0, 0);
    rd0   = mk_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
    w1    = mk_d(0, 0, 3, 3, 5, 0, 0, 0, 0);
    w2    = mk_d(0, 5, 3, 2, 5, 0, 0, 0, 0);
    w3    = mk_d(0, 0, 3, 3, 5, 0, 0, 0, 0);
    rd5   = mk_d(5, 0, 0, 3, 0, 0, 0, 0, 0);
    mult  = mk_d(11, 12, 1, 1, 0, 0, 1, 1, 0);
    divi  = mk_d(11, 12, 1, 1, 0, 0, 1, 1, 1);
    mfhi  = mk_d(0, 0, 3, 3, 13, 1, 1, 0, 0);
    z     = '0;
    st    = mk_e(1, 0, 0, 0, 0, 0, 0);
    busy  = mk_e(1, 0, 0, 0, 0, 0, 1);

    // Reset state, even with a hazardous-looking D instruction
    reset = 1'b0;
    apply(add4);
    expect_now(z, "reset_state");
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    apply(nop);
    drive(nop, z, "flush0");
    drive(nop, z, "flush1");

    // Load-use: one stall cycle, then E forwards from W
    drive(lw1,  z,                         "lw_issue");
    drive(add4, st,                        "lu_stall");
    drive(add4, z,                         "lu_release");
    drive(nop,  mk_e(0, 0, 0, 2, 0, 0, 0), "lu_fwd_e_w");

    // Branch after ALU, then jal/jr forwarding from E
    drive(add3,  z,                         "add3_issue");
    drive(beq3,  st,                        "br_stall");
    drive(beq3,  mk_e(0, 2, 0, 0, 0, 0, 0), "br_fwd_d_m");
    drive(jal31, mk_e(0, 0, 0, 2, 0, 0, 0), "br_fwd_e_w");
    drive(jr31,  mk_e(0, 1, 0, 0, 0, 0, 0), "jr_fwd_d_e");

    // $0 writer and readers
    drive(add0, mk_e(0, 0, 0, 1, 0, 0, 0), "jr_fwd_e_m");
    drive(rd0,  z,                         "zero_reg_d");
    drive(nop,  z,                         "zero_reg_e");

    // Priority E > M > W, plus store-data forward from W
    drive(w1,  z,                         "w1_issue");
    drive(w2,  mk_e(0, 0, 1, 0, 0, 0, 0), "w2_fwd_d_e");
    drive(w3,  mk_e(0, 0, 0, 0, 1, 0, 0), "w3_fwd_e_m");
    drive(rd5, mk_e(0, 1, 0, 0, 0, 1, 0), "prio_e");
    drive(rd5, mk_e(0, 2, 0, 1, 0, 0, 0), "prio_m");
    drive(nop, mk_e(0, 0, 0, 2, 0, 0, 0), "prio_e_w");

    // mult then mfhi: 6 stall cycles
    drive(mult, z, "mult_issue");
    for (int i = 0; i < 6; i++) drive(mfhi, busy, "mult_wait");
    drive(mfhi, z, "mult_done");

    // div then mfhi: 11 stall cycles
    drive(divi, z, "div_issue");
    for (int i = 0; i < 11; i++) drive(mfhi, busy, "div_wait");
    drive(mfhi, z, "div_done");

    // Reset mid-divide while the counter holds 7
    drive(divi, z, "div2_issue");
    for (int i = 0; i < 4; i++) drive(mfhi, busy, "div2_wait");
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply(mfhi);
    expect_now(z, "rst_mid_div");
    @(posedge clk);
    #1;
    expect_now(z, "rst_held");
    @(posedge clk);
    #1;
    reset = 1'b1;
    apply(mfhi);
    expect_now(z, "post_rst_md");
    drive(mfhi, z, "post_rst_md2");
    drive(nop,  z, "post_rst_nop");

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Pipeline hazard and forwarding controller for the 5-stage MIPS core (F/D/E/M/W).
- Keeps its own shadow copies of E/M/W destination-register and Tnew information.
- Uses the Tuse/Tnew model to drive the select inputs of the D-, E- and M-stage forwarding muxes (4-input and 2-input, 32-bit).
- Asserts stall for load-use hazards and for HI/LO access while the multiply/divide unit is busy, which it tracks with a cycle counter.

Parameters:
- MULT_CYCLES, 5, busy cycles loaded for mult/multu
- DIV_CYCLES, 10, busy cycles loaded for div/divu

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- D_rs  in  5  rs field of the instruction in D
- D_rt  in  5  rt field of the instruction in D
- D_tuse_rs  in  2  cycles until rs is needed (0=D, 1=E, 2=M, 3=unused)
- D_tuse_rt  in  2  same encoding, for rt
- D_wa  in  5  destination register of the D instruction (0 = none)
- D_tnew  in  2  cycles after entering E until the result exists (jal 0, ALU 1, load 2)
- D_md  in  1  D instruction reads or writes HI/LO or starts the MDU
- D_md_start  in  1  D instruction is mult/multu/div/divu
- D_md_div  in  1  qualifies D_md_start: 1 = divide
- stall  out  1  freeze PC and F/D registers, insert bubble into E
- fwd_d_rs_sel  out  2  D rs mux: 0 RF, 1 E (PC+8), 2 M result, 3 W result
- fwd_d_rt_sel  out  2  same encoding, for rt
- fwd_e_rs_sel  out  2  E rs mux: 0 pipeline register, 1 M result, 2 W result (3 unused)
- fwd_e_rt_sel  out  2  same encoding, for rt
- fwd_m_rt_sel  out  1  M store-data mux: 0 pipeline register, 1 W result
- md_busy  out  1  MDU busy (E holds a start, or counter nonzero)

Behaviour:
- Shadow state per stage:
  - E: rs, rt, wa, tnew, md_start.
  - M: rt, wa, tnew.
  - W: wa, tnew.
  - Also mdu_cnt, 4 bits.
- Reset (reset=0, asynchronous): all shadow fields and mdu_cnt = 0; consequently stall=0, all sel=0, md_busy=0. Reset is honoured mid-operation, including mid-divide: md_busy drops immediately.
- Every rising clk edge with reset=1:
  - M <= E, with tnew = max(E.tnew-1, 0).
  - W <= M, with tnew = max(M.tnew-1, 0).
  - If stall=0: E <= D fields. If stall=1: E <= bubble (wa=0, tnew=0, md_start=0).
- MDU counter:
  - When E.md_start=1, mdu_cnt loads MULT_CYCLES or DIV_CYCLES on the edge that moves it to M. The divide flag is held in the E shadow.
  - Otherwise mdu_cnt decrements and saturates at 0.
- md_busy = E.md_start | (mdu_cnt != 0). Combinational.
- Register-file value is ready when a stage's tnew = 0.
- Register-hazard stall (for each source r of the D instruction, with tuse t):
  - Conditions: r != 0, t != 3, and the nearest of E/M with wa == r has tnew > t.
  - W always has tnew = 0 and never stalls.
- MDU stall: D_md & md_busy.
- stall = OR of all hazard terms. Combinational from D inputs and current shadows; no added latency.
- D forward select for source r, priority E > M > W:
  - Pick the first stage with wa == r, r != 0 and tnew = 0. Result: 1/2/3 for E/M/W; 0 if none.
  - A matching stage with tnew > 0 yields 0, and the stall covers it.
- E forward: same rule against E.rs/E.rt, searching M then W. Result: 1 = M, 2 = W.
- M forward: fwd_m_rt_sel = 1 iff W.wa == M.rt, M.rt != 0 and W.tnew = 0.
- Register $0: never forwarded and never stalled.
- Simultaneous events:
  - A stall with an MDU start in D inserts a bubble; the start is not lost, because D is re-presented.
  - Register and MDU hazards are ORed.

Test Plan:
- Load-use: lw $1 (D_tnew=2) then addu with rs=$1 (tuse 1) → stall=1 for exactly 1 cycle. Then, with addu in E and lw in W, fwd_e_rs_sel=2.
- Branch after ALU: addu $3 (tnew 1) then beq with rs=$3 (tuse 0) → 1 stall cycle, then fwd_d_rs_sel=2. With jal (wa=31, tnew 0) in E and jr $31 in D → fwd_d_rs_sel=1, no stall.
- $0 writer: addu $0 followed by any reader of $0 → stall=0, all sel=0.
- Priority: E, M and W all writing $5 with tnew 0, D reads $5 → fwd_d_rs_sel=1. With only M and W matching → 2.
- MDU: mult, then mfhi held in D → md_busy=1 and stall=1 for 6 consecutive cycles (1 with mult in E, then 5 while mdu_cnt counts down). div gives 11 cycles; mfhi issues in the following cycle.
- Reset mid-divide: reset=0 while mdu_cnt=7 → stall, md_busy and all sel go to 0 asynchronously. After release, no stall is seen for a D_md instruction.
